con_port_arbiter: RTL

Two-requester arbiter sharing the single 32-bit datamem side port (11-bit word address, 4-bit byte write enable) of a core between the protocol controller block and a second bus master (e.g. a debug/dump engine). It grants at most one access per cycle, round-robin by default, with a bounded lock for bursts. It routes 1-cycle-latency read data back to the requester that issued the read. It sits between the requesters and the core's `con_*` port.

---
 rtl/con_port_arbiter_pkg.sv | 14 +
 rtl/arb_rr2_pick.sv | 26 ++
 rtl/con_port_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/con_port_arbiter_pkg.sv
// Shared widths and requester ids for the datamem side-port arbiter.
package con_port_arbiter_pkg;

    localparam int CON_ADDR_W    = 11;
    localparam int CON_DATA_W    = 32;
    localparam int CON_BE_W      = 4;
    localparam int CON_MAX_BURST = 8;

    typedef enum logic {
        REQ_R0 = 1'b0,
        REQ_R1 = 1'b1
    } req_id_e;

endpackage

// File: rtl/arb_rr2_pick.sv
// Two-way round-robin pick with bounded lock; purely combinational, no backpressure of its own.
module arb_rr2_pick (
    input  logic [1:0] req,
    input  logic [1:0] lock,
    input  logic       owner,
    input  logic       burst_at_max,
    output logic [1:0] gnt,
    output logic       winner
);

    always_comb begin
        gnt    = 2'b00;
        winner = owner;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            // Contention: the owner keeps the port only while locked and under its burst budget.
            2'b11:   winner = (lock[owner] && !burst_at_max) ? owner : ~owner;
            default: winner = owner;
        endcase
        if (req != 2'b00) begin
            gnt[winner] = 1'b1;
        end
    end

endmodule

// File: rtl/con_port_arbiter.sv
// Shares the core datamem side port between two masters: 0-cycle grant, 1-cycle read return.
// A requester holds req until gnt; the losing side simply waits (bounded by MAX_BURST under lock).
module con_port_arbiter
    import con_port_arbiter_pkg::*;
#(
    parameter int ADDR_W    = CON_ADDR_W,
    parameter int DATA_W    = CON_DATA_W,
    parameter int BE_W      = CON_BE_W,
    parameter int MAX_BURST = CON_MAX_BURST
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              r0_req,
    input  logic              r0_lock,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [BE_W-1:0]   r0_wr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_lock,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [BE_W-1:0]   r1_wr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BE_W-1:0]   mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    req_id_e           r_owner;
    req_id_e           r_rd_id;
    logic              r_rd_pend;
    logic [CNT_W-1:0]  r_burst_cnt;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    logic [1:0]        w_req;
    logic [1:0]        w_lock;
    logic [1:0]        w_gnt;
    logic              w_winner;
    logic              w_access;
    logic              w_rd_access;
    logic              w_burst_at_max;
    logic [ADDR_W-1:0] w_win_addr;
    logic [BE_W-1:0]   w_win_wr;
    logic [DATA_W-1:0] w_win_wdata;

    assign w_req          = {r1_req, r0_req};
    assign w_lock         = {r1_lock, r0_lock};
    assign w_burst_at_max = (r_burst_cnt == CNT_W'(MAX_BURST));

    arb_rr2_pick u_pick (
        .req          (w_req),
        .lock         (w_lock),
        .owner        (r_owner),
        .burst_at_max (w_burst_at_max),
        .gnt          (w_gnt),
        .winner       (w_winner)
    );

    assign r0_gnt      = w_gnt[0];
    assign r1_gnt      = w_gnt[1];
    assign w_access    = |w_gnt;
    assign w_win_addr  = w_winner ? r1_addr  : r0_addr;
    assign w_win_wr    = w_winner ? r1_wr    : r0_wr;
    assign w_win_wdata = w_winner ? r1_wdata : r0_wdata;
    assign w_rd_access = w_access && (w_win_wr == '0);

    // Idle cycles drive zeros so a stray requester field can never reach the core as a write.
    assign mem_addr  = w_access ? w_win_addr  : '0;
    assign mem_wr    = w_access ? w_win_wr    : '0;
    assign mem_wdata = w_access ? w_win_wdata : '0;
    assign owner     = r_owner;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_owner     <= REQ_R1;
            r_burst_cnt <= '0;
            r_rd_pend   <= 1'b0;
            r_rd_id     <= REQ_R0;
        end else begin
            r_rd_pend <= w_rd_access;
            if (w_rd_access) begin
                r_rd_id <= req_id_e'(w_winner);
            end
            if (w_access) begin
                r_owner <= req_id_e'(w_winner);
                if ((req_id_e'(w_winner) != r_owner) || !w_lock[w_winner]) begin
                    r_burst_cnt <= '0;
                end else if (!w_burst_at_max) begin
                    r_burst_cnt <= r_burst_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign r0_rvalid = r_rd_pend && (r_rd_id == REQ_R0);
    assign r1_rvalid = r_rd_pend && (r_rd_id == REQ_R1);

    // Core data arrives in the rvalid cycle; the hold register keeps it visible afterwards.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (r0_rvalid) begin
                r_rdata0 <= mem_rdata;
            end
            if (r1_rvalid) begin
                r_rdata1 <= mem_rdata;
            end
        end
    end

    assign r0_rdata = r0_rvalid ? mem_rdata : r_rdata0;
    assign r1_rdata = r1_rvalid ? mem_rdata : r_rdata1;

endmodule
